// File: rtl/score_tracker.sv
// score_tracker: penalty-shootout score keeper.
// Counts regulation kicks and goals for player and enemy, detects an early
// decision during regulation, and optionally runs sudden-death pairs after a
// regulation tie.
// Optional feature macro: SCORE_TRACKER_SUDDEN_DEATH_EN
//   defined   -> a regulation tie enters sudden death (kick pairs until decided)
//   undefined -> a regulation tie ends the match as a loss; sudden_death = 0

package game_pkg;
   typedef enum logic [2:0] {
      START   = 3'd0,
      KEEPER  = 3'd1,
      SHOOTER = 3'd2,
      WINNER  = 3'd3,
      LOSER   = 3'd4
   } g_state;
endpackage

module score_tracker
   import game_pkg::*;
#(
   parameter int ROUNDS = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  g_state     game_state,
   input  logic       shot_done,
   input  logic       shot_goal,
   output logic       match_end,
   output logic       match_result,
   output logic [7:0] player_score,
   output logic [7:0] enemy_score,
   output logic [3:0] player_kicks,
   output logic [3:0] enemy_kicks,
   output logic       sudden_death
);

   localparam logic [3:0] ROUNDS_K = 4'(ROUNDS);

   logic [7:0] player_score_q, player_score_d;
   logic [7:0] enemy_score_q,  enemy_score_d;
   logic [3:0] player_kicks_q, player_kicks_d;
   logic [3:0] enemy_kicks_q,  enemy_kicks_d;
   logic       match_end_q,    match_end_d;
   logic       match_result_q, match_result_d;

   logic       kick_accept;
   logic       kick_player;
   logic       sd_active;
   logic [9:0] p_wide, e_wide, p_left, e_left;

`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
   logic       sudden_death_q, sudden_death_d;
   logic       pending_q,      pending_d;
   logic       pending_side_q, pending_side_d;   // 1 = player opened the pair
`endif

   // Kick qualification: only live shooter/keeper phases of an undecided match
   always_comb begin
      kick_accept = shot_done && !match_end_q &&
                    ((game_state == SHOOTER) || (game_state == KEEPER));
      kick_player = (game_state == SHOOTER);
`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
      sd_active   = sudden_death_q;
`else
      sd_active   = 1'b0;
`endif
   end

   // Next-state: counters, scores and the match decision from post-kick values
   always_comb begin
      // NOTE: every _d gets a default first so no path can infer a latch, and
      // blocking assignments let the decision below read the post-kick values.
      player_score_d = player_score_q;
      enemy_score_d  = enemy_score_q;
      player_kicks_d = player_kicks_q;
      enemy_kicks_d  = enemy_kicks_q;
      match_end_d    = match_end_q;
      match_result_d = match_result_q;
`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
      sudden_death_d = sudden_death_q;
      pending_d      = pending_q;
      pending_side_d = pending_side_q;
`endif
      p_wide = '0;
      e_wide = '0;
      p_left = '0;
      e_left = '0;

      if (game_state == START) begin
         // New match: clear everything, any simultaneous kick is dropped
         player_score_d = '0;
         enemy_score_d  = '0;
         player_kicks_d = '0;
         enemy_kicks_d  = '0;
         match_end_d    = 1'b0;
         match_result_d = 1'b0;
`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
         sudden_death_d = 1'b0;
         pending_d      = 1'b0;
         pending_side_d = 1'b0;
`endif
      end else if (kick_accept) begin
         if (kick_player) begin
            if (player_kicks_q != ROUNDS_K) player_kicks_d = player_kicks_q + 4'd1;
            if (shot_goal && (player_score_q != 8'hFF)) player_score_d = player_score_q + 8'd1;
         end else begin
            if (enemy_kicks_q != ROUNDS_K) enemy_kicks_d = enemy_kicks_q + 4'd1;
            if (shot_goal && (enemy_score_q != 8'hFF)) enemy_score_d = enemy_score_q + 8'd1;
         end

         p_wide = {2'b00, player_score_d};
         e_wide = {2'b00, enemy_score_d};
         p_left = {6'd0, ROUNDS_K - player_kicks_d};
         e_left = {6'd0, ROUNDS_K - enemy_kicks_d};

         if (!sd_active) begin
            // Regulation: decide as soon as the trailing side cannot catch up
            if (p_wide > e_wide + e_left) begin
               match_end_d    = 1'b1;
               match_result_d = 1'b1;
            end else if (e_wide > p_wide + p_left) begin
               match_end_d    = 1'b1;
               match_result_d = 1'b0;
            end else if ((player_kicks_d == ROUNDS_K) && (enemy_kicks_d == ROUNDS_K)) begin
               // Only reachable with equal scores: both exhausted and undecided
`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
               sudden_death_d = 1'b1;
`else
               match_end_d    = 1'b1;
               match_result_d = 1'b0;
`endif
            end
         end
`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
         else begin
            // Sudden death: evaluate only when the opposite side closes the pair
            if (!pending_q) begin
               pending_d      = 1'b1;
               pending_side_d = kick_player;
            end else if (pending_side_q != kick_player) begin
               pending_d = 1'b0;
               if (player_score_d != enemy_score_d) begin
                  match_end_d    = 1'b1;
                  match_result_d = (player_score_d > enemy_score_d);
                  sudden_death_d = 1'b0;
               end
            end
         end
`endif
      end
   end

   // State register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         player_score_q <= '0;
         enemy_score_q  <= '0;
         player_kicks_q <= '0;
         enemy_kicks_q  <= '0;
         match_end_q    <= 1'b0;
         match_result_q <= 1'b0;
`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
         sudden_death_q <= 1'b0;
         pending_q      <= 1'b0;
         pending_side_q <= 1'b0;
`endif
      end else begin
         player_score_q <= player_score_d;
         enemy_score_q  <= enemy_score_d;
         player_kicks_q <= player_kicks_d;
         enemy_kicks_q  <= enemy_kicks_d;
         match_end_q    <= match_end_d;
         match_result_q <= match_result_d;
`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
         sudden_death_q <= sudden_death_d;
         pending_q      <= pending_d;
         pending_side_q <= pending_side_d;
`endif
      end
   end

   assign player_score = player_score_q;
   assign enemy_score  = enemy_score_q;
   assign player_kicks = player_kicks_q;
   assign enemy_kicks  = enemy_kicks_q;
   assign match_end    = match_end_q;
   assign match_result = match_result_q;
`ifdef SCORE_TRACKER_SUDDEN_DEATH_EN
   assign sudden_death = sudden_death_q;
`else
   assign sudden_death = 1'b0;
`endif

endmodule
